// File: rtl/decode_issue_stage_pkg.sv
// Shared pipeline encodings and the issue-slot record used by decode/issue.
// No logic of its own; consumed by the stage, its interface and its helpers.
// Encodings here are the single source for WB_* / MEM_* across the pipeline.
package decode_issue_stage_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;
  localparam int WBW  = 3;
  localparam int MOPW = 5;

  localparam logic [XLEN-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  // Write-back source select; bit 2 marks "result comes from data memory"
  localparam logic [WBW-1:0] WB_RESULT      = 3'b001;
  localparam logic [WBW-1:0] WB_CSR_DATAOUT = 3'b010;
  localparam logic [WBW-1:0] WB_DATAMEM     = 3'b100;

  // Memory access class, carried in mem_op[4:3]; mem_op[2:0] is size/sign
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_READ  = 2'b10
  } mem_kind_e;

  // Everything the execute stage receives for one issued instruction
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [RIDX-1:0] rd;
    logic [WBW-1:0]  wb_src;
    logic [MOPW-1:0] mem_op;
  } issue_t;

  // x0 always reads as zero; otherwise the forwarding network wins over the RF
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [RIDX-1:0] rs,
    input logic            fwd_sel,
    input logic [XLEN-1:0] fwd_data,
    input logic [XLEN-1:0] rf_data
  );
    if (rs == '0) return '0;
    return fwd_sel ? fwd_data : rf_data;
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Bundle between decode, register file/forwarding, in-flight producers and execute.
// Pure wiring, no latency.
// slave = issue stage side, master = environment side (decode, execute, hazard sources).
interface decode_issue_stage_if;
  import decode_issue_stage_pkg::*;

  // Decode handshake and decoded fields
  logic            de_valid;
  logic            de_ready;
  logic [XLEN-1:0] de_pc;
  logic [XLEN-1:0] de_imm;
  logic [RIDX-1:0] de_rs1;
  logic [RIDX-1:0] de_rs2;
  logic [RIDX-1:0] de_rd;
  logic            de_use_rs1;
  logic            de_use_rs2;
  logic [WBW-1:0]  de_wb_src;
  logic [MOPW-1:0] de_mem_op;

  // Operand sources
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            fwd_sel1;
  logic            fwd_sel2;
  logic [XLEN-1:0] fwd_data1;
  logic [XLEN-1:0] fwd_data2;

  // In-flight producers for load-use detection
  logic [RIDX-1:0] ex_rd_in;
  logic [RIDX-1:0] m1_rd_in;
  logic [WBW-1:0]  ex_wb_src_in;
  logic [WBW-1:0]  m1_wb_src_in;
  logic [MOPW-1:0] ex_mem_op_in;
  logic [MOPW-1:0] m1_mem_op_in;

  // Control
  logic            flush;
  logic            ex_ready;

  // Issue to execute
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_imm;
  logic [RIDX-1:0] ex_rd;
  logic [WBW-1:0]  ex_wb_src;
  logic [MOPW-1:0] ex_mem_op;
  logic [XLEN-1:0] stall_cnt;

  modport slave (
    input  de_valid, de_pc, de_imm, de_rs1, de_rs2, de_rd, de_use_rs1, de_use_rs2,
    input  de_wb_src, de_mem_op,
    input  rf_rdata1, rf_rdata2, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2,
    input  ex_rd_in, m1_rd_in, ex_wb_src_in, m1_wb_src_in, ex_mem_op_in, m1_mem_op_in,
    input  flush, ex_ready,
    output de_ready,
    output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_wb_src, ex_mem_op,
    output stall_cnt
  );

  modport master (
    output de_valid, de_pc, de_imm, de_rs1, de_rs2, de_rd, de_use_rs1, de_use_rs2,
    output de_wb_src, de_mem_op,
    output rf_rdata1, rf_rdata2, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2,
    output ex_rd_in, m1_rd_in, ex_wb_src_in, m1_wb_src_in, ex_mem_op_in, m1_mem_op_in,
    output flush, ex_ready,
    input  de_ready,
    input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_wb_src, ex_mem_op,
    input  stall_cnt
  );

endinterface

// File: rtl/decode_issue_stage_load_use_detect.sv
// Load-use hazard detection against loads sitting in EX and M1.
// Latency: purely combinational.
// No handshake; the result gates the issue stage's de_ready.
module load_use_detect
  import decode_issue_stage_pkg::*;
(
  input  logic [RIDX-1:0] rs1_i,
  input  logic [RIDX-1:0] rs2_i,
  input  logic            use_rs1_i,
  input  logic            use_rs2_i,
  input  logic [RIDX-1:0] ex_rd_i,
  input  logic [WBW-1:0]  ex_wb_src_i,
  input  logic [MOPW-1:0] ex_mem_op_i,
  input  logic [RIDX-1:0] m1_rd_i,
  input  logic [WBW-1:0]  m1_wb_src_i,
  input  logic [MOPW-1:0] m1_mem_op_i,
  output logic            hazard_o
);

  logic ex_is_load;
  logic m1_is_load;
  logic ex_match;
  logic m1_match;

  // A producer only blocks when its data comes from memory and is not yet available
  assign ex_is_load = ex_wb_src_i[2] && (ex_mem_op_i[4:3] == MEM_READ) && (ex_rd_i != '0);
  assign m1_is_load = m1_wb_src_i[2] && (m1_mem_op_i[4:3] == MEM_READ) && (m1_rd_i != '0);

  // Only operands the instruction actually reads can create a dependency
  assign ex_match = (use_rs1_i && (rs1_i == ex_rd_i)) || (use_rs2_i && (rs2_i == ex_rd_i));
  assign m1_match = (use_rs1_i && (rs1_i == m1_rd_i)) || (use_rs2_i && (rs2_i == m1_rd_i));

  assign hazard_o = (ex_is_load && ex_match) || (m1_is_load && m1_match);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue register: resolves operands and hands one instruction per cycle to execute.
// Latency: one cycle from accept to ex_valid.
// Holds while execute stalls; stalls decode on load-use hazards (counted in stall_cnt).
module decode_issue_stage
  import decode_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  decode_issue_stage_if.slave bus
);

  logic            hazard;
  logic            de_ready;
  logic            accept;
  logic            ex_valid_d;
  logic            ex_valid_q;
  issue_t          issue_d;
  issue_t          issue_q;
  logic [XLEN-1:0] stall_cnt_d;
  logic [XLEN-1:0] stall_cnt_q;

  load_use_detect u_load_use_detect (
    .rs1_i       (bus.de_rs1),
    .rs2_i       (bus.de_rs2),
    .use_rs1_i   (bus.de_use_rs1),
    .use_rs2_i   (bus.de_use_rs2),
    .ex_rd_i     (bus.ex_rd_in),
    .ex_wb_src_i (bus.ex_wb_src_in),
    .ex_mem_op_i (bus.ex_mem_op_in),
    .m1_rd_i     (bus.m1_rd_in),
    .m1_wb_src_i (bus.m1_wb_src_in),
    .m1_mem_op_i (bus.m1_mem_op_in),
    .hazard_o    (hazard)
  );

  // Flush deliberately does not gate de_ready: the redirect is handled by killing ex_valid
  assign de_ready     = !hazard && (!ex_valid_q || bus.ex_ready);
  assign accept       = bus.de_valid && de_ready;
  assign bus.de_ready = de_ready;

  // Next issue-slot contents: flush kills, accept loads, drained slot becomes a bubble
  always_comb begin
    ex_valid_d  = ex_valid_q;
    issue_d     = issue_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d     = 1'b1;
      issue_d.pc     = bus.de_pc;
      issue_d.op1    = resolve_operand(bus.de_rs1, bus.fwd_sel1, bus.fwd_data1, bus.rf_rdata1);
      issue_d.op2    = resolve_operand(bus.de_rs2, bus.fwd_sel2, bus.fwd_data2, bus.rf_rdata2);
      issue_d.imm    = bus.de_imm;
      issue_d.rd     = bus.de_rd;
      issue_d.wb_src = bus.de_wb_src;
      issue_d.mem_op = bus.de_mem_op;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end

    if (bus.de_valid && hazard && !bus.flush && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset that wins over flush and accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      issue_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      issue_q     <= issue_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_pc     = issue_q.pc;
  assign bus.ex_op1    = issue_q.op1;
  assign bus.ex_op2    = issue_q.op2;
  assign bus.ex_imm    = issue_q.imm;
  assign bus.ex_rd     = issue_q.rd;
  assign bus.ex_wb_src = issue_q.wb_src;
  assign bus.ex_mem_op = issue_q.mem_op;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed scenarios then random traffic.
// Inputs change at posedge+2, de_ready is checked at posedge+3, outputs at posedge+1.
// Expected issues are queued by the driver and popped by an independent monitor.
`timescale 1ns/1ps
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_issue_stage_if bus();

  decode_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  issue_t      exp_q[$];
  bit          mon_en  = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_new   = 1'b0;
  bit          m_rst   = 1'b0;
  logic [31:0] m_cnt   = '0;
  int          bubbles = 0;
  logic [31:0] base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_issue(input string name, input issue_t act, input issue_t exp);
    chk({name, ".pc"},     act.pc,            exp.pc);
    chk({name, ".op1"},    act.op1,           exp.op1);
    chk({name, ".op2"},    act.op2,           exp.op2);
    chk({name, ".imm"},    act.imm,           exp.imm);
    chk({name, ".rd"},     32'(act.rd),       32'(exp.rd));
    chk({name, ".wb_src"}, 32'(act.wb_src),   32'(exp.wb_src));
    chk({name, ".mem_op"}, 32'(act.mem_op),   32'(exp.mem_op));
  endtask

  // ---------------- reference model (rule level) ----------------
  function automatic bit producer_blocks(input logic [4:0] rd, input logic [2:0] wb,
                                         input logic [4:0] mop);
    if (!(wb[2] && mop[4:3] == MEM_READ) || rd == 5'd0) return 1'b0;
    return (bus.de_use_rs1 && bus.de_rs1 == rd) || (bus.de_use_rs2 && bus.de_rs2 == rd);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic sel,
                                          input logic [31:0] f, input logic [31:0] r);
    if (rs == 5'd0) return 32'd0;
    return sel ? f : r;
  endfunction

  // One clock: check de_ready, predict the edge, advance to posedge+2
  task automatic cycle();
    bit hz, rdy, acc;
    issue_t e;
    #1;
    hz  = producer_blocks(bus.ex_rd_in, bus.ex_wb_src_in, bus.ex_mem_op_in) ||
          producer_blocks(bus.m1_rd_in, bus.m1_wb_src_in, bus.m1_mem_op_in);
    rdy = !hz && (!m_valid || bus.ex_ready);
    chk("de_ready", 32'(bus.de_ready), 32'(rdy));
    if (bus.de_ready !== 1'b1) bubbles++;
    acc = bus.de_valid && rdy;
    if (rst) begin
      m_rst = 1'b1; m_new = 1'b0; m_valid = 1'b0; m_cnt = '0;
    end else begin
      m_rst = 1'b0;
      m_new = acc && !bus.flush;
      if (m_new) begin
        e.pc     = bus.de_pc;
        e.op1    = operand(bus.de_rs1, bus.fwd_sel1, bus.fwd_data1, bus.rf_rdata1);
        e.op2    = operand(bus.de_rs2, bus.fwd_sel2, bus.fwd_data2, bus.rf_rdata2);
        e.imm    = bus.de_imm;
        e.rd     = bus.de_rd;
        e.wb_src = bus.de_wb_src;
        e.mem_op = bus.de_mem_op;
        exp_q.push_back(e);
      end
      if (bus.flush)         m_valid = 1'b0;
      else if (acc)          m_valid = 1'b1;
      else if (bus.ex_ready) m_valid = 1'b0;
      if (bus.de_valid && hz && !bus.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    issue_t cur, last, e, zero;
    zero = '0;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("stall_cnt", bus.stall_cnt, m_cnt);
        cur.pc = bus.ex_pc;   cur.op1 = bus.ex_op1; cur.op2 = bus.ex_op2;
        cur.imm = bus.ex_imm; cur.rd = bus.ex_rd;   cur.wb_src = bus.ex_wb_src;
        cur.mem_op = bus.ex_mem_op;
        if (m_rst) begin
          chk_issue("reset", cur, zero);
          last = zero;
        end else if (m_new) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL issue: DUT loaded pc 0x%08h, expected no pending entry", cur.pc);
          end else begin
            e = exp_q.pop_front();
            chk_issue("issue", cur, e);
            last = e;
          end
        end else begin
          chk_issue("hold", cur, last);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_prod();
    bus.ex_rd_in = '0; bus.ex_wb_src_in = WB_RESULT; bus.ex_mem_op_in = '0;
    bus.m1_rd_in = '0; bus.m1_wb_src_in = WB_RESULT; bus.m1_mem_op_in = '0;
  endtask

  task automatic set_idle();
    rst = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.de_valid = 1'b0;
    bus.de_pc = '0; bus.de_imm = '0; bus.de_rs1 = '0; bus.de_rs2 = '0; bus.de_rd = '0;
    bus.de_use_rs1 = 1'b0; bus.de_use_rs2 = 1'b0; bus.de_wb_src = WB_RESULT; bus.de_mem_op = '0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.fwd_sel1 = 1'b0; bus.fwd_sel2 = 1'b0;
    bus.fwd_data1 = '0; bus.fwd_data2 = '0;
    clr_prod();
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input bit u1,
                           input logic [4:0] rs2, input bit u2, input logic [4:0] rd);
    bus.de_valid = 1'b1; bus.de_pc = pc; bus.de_imm = pc ^ 32'h0000_5555;
    bus.de_rs1 = rs1; bus.de_use_rs1 = u1; bus.de_rs2 = rs2; bus.de_use_rs2 = u2;
    bus.de_rd = rd; bus.de_wb_src = WB_RESULT; bus.de_mem_op = '0;
    bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom;
  endtask

  function automatic logic [2:0] pick_wb();
    case ($urandom_range(0, 3))
      0:       return WB_RESULT;
      1:       return WB_CSR_DATAOUT;
      default: return WB_DATAMEM;
    endcase
  endfunction

  function automatic logic [4:0] pick_mop();
    logic [1:0] k;
    k = ($urandom_range(0, 1) == 0) ? MEM_READ : 2'($urandom_range(0, 3));
    return {k, 3'($urandom_range(0, 7))};
  endfunction

  task automatic set_random();
    rst = ($urandom_range(0, 99) == 0);
    bus.flush = ($urandom_range(0, 15) == 0);
    bus.ex_ready = ($urandom_range(0, 3) != 0);
    bus.de_valid = ($urandom_range(0, 4) != 0);
    bus.de_pc = $urandom; bus.de_imm = $urandom;
    bus.de_rs1 = 5'($urandom_range(0, 3)); bus.de_rs2 = 5'($urandom_range(0, 3));
    bus.de_rd = 5'($urandom_range(0, 31));
    bus.de_use_rs1 = 1'($urandom_range(0, 1)); bus.de_use_rs2 = 1'($urandom_range(0, 1));
    bus.de_wb_src = pick_wb(); bus.de_mem_op = pick_mop();
    bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom;
    bus.fwd_sel1 = 1'($urandom_range(0, 1)); bus.fwd_sel2 = 1'($urandom_range(0, 1));
    bus.fwd_data1 = $urandom; bus.fwd_data2 = $urandom;
    bus.ex_rd_in = 5'($urandom_range(0, 3)); bus.ex_wb_src_in = pick_wb();
    bus.ex_mem_op_in = pick_mop();
    bus.m1_rd_in = 5'($urandom_range(0, 3)); bus.m1_wb_src_in = pick_wb();
    bus.m1_mem_op_in = pick_mop();
  endtask

  task automatic load_ex(input logic [4:0] rd);
    bus.ex_rd_in = rd; bus.ex_wb_src_in = WB_DATAMEM; bus.ex_mem_op_in = {MEM_READ, 3'b010};
  endtask

  task automatic load_m1(input logic [4:0] rd);
    bus.m1_rd_in = rd; bus.m1_wb_src_in = WB_DATAMEM; bus.m1_mem_op_in = {MEM_READ, 3'b010};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_idle();
    rst = 1'b1; m_rst = 1'b1; m_valid = 1'b0; m_cnt = '0;
    mon_en = 1'b1;
    @(posedge clk);
    #2;
    cycle();
    rst = 1'b0;

    // Forwarded ALU result from EX: no stall, forwarded value issued
    set_idle(); bus.ex_rd_in = 5'd5;
    set_instr(32'h100, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    bus.fwd_sel1 = 1'b1; bus.fwd_data1 = 32'h1234; bus.rf_rdata1 = 32'h0BAD;
    bubbles = 0;
    cycle();
    chk("alu_fwd_stalls", bubbles, 0);
    chk("alu_fwd_valid", 32'(bus.ex_valid), 1);
    chk("alu_fwd_op1", bus.ex_op1, 32'h1234);

    // Load in EX, dependent rs2: two bubbles then issue with forwarded value
    set_idle(); cycle();
    base = m_cnt; bubbles = 0;
    set_instr(32'h200, 5'd1, 1'b0, 5'd7, 1'b1, 5'd8);
    load_ex(5'd7); cycle();
    clr_prod(); load_m1(5'd7); cycle();
    clr_prod(); bus.fwd_sel2 = 1'b1; bus.fwd_data2 = 32'hCAFE_F00D; cycle();
    chk("lu_ex_bubbles", bubbles, 2);
    chk("lu_ex_stall_cnt", bus.stall_cnt, base + 32'd2);
    chk("lu_ex_op2", bus.ex_op2, 32'hCAFE_F00D);
    chk("lu_ex_pc", bus.ex_pc, 32'h200);

    // Load in M1 only: one bubble
    set_idle(); cycle(); bubbles = 0;
    set_instr(32'h300, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9);
    load_m1(5'd7); cycle();
    clr_prod(); cycle();
    chk("lu_m1_bubbles", bubbles, 1);
    chk("lu_m1_pc", bus.ex_pc, 32'h300);

    // Unused operand and x0 never stall
    set_idle(); cycle(); bubbles = 0;
    set_instr(32'h400, 5'd1, 1'b1, 5'd7, 1'b0, 5'd3);
    load_ex(5'd7); cycle();
    chk("unused_rs_bubbles", bubbles, 0);
    chk("unused_rs_pc", bus.ex_pc, 32'h400);
    set_idle(); bubbles = 0;
    set_instr(32'h500, 5'd0, 1'b1, 5'd2, 1'b0, 5'd3);
    bus.rf_rdata1 = 32'hDEAD; bus.fwd_sel1 = 1'b1; bus.fwd_data1 = 32'hBEEF;
    load_ex(5'd0); cycle();
    chk("x0_bubbles", bubbles, 0);
    chk("x0_op1", bus.ex_op1, 32'd0);

    // Execute backpressure: hold three cycles, then next instruction loads
    set_idle(); set_instr(32'h600, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4); cycle();
    set_instr(32'h700, 5'd3, 1'b1, 5'd1, 1'b1, 5'd5);
    bus.ex_ready = 1'b0; bubbles = 0;
    repeat (3) begin
      cycle();
      chk("bp_hold_pc", bus.ex_pc, 32'h600);
    end
    chk("bp_bubbles", bubbles, 3);
    bus.ex_ready = 1'b1; cycle();
    chk("bp_release_pc", bus.ex_pc, 32'h700);
    chk("bp_release_valid", 32'(bus.ex_valid), 1);

    // Flush coincident with accept
    set_idle(); set_instr(32'h800, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6);
    bus.flush = 1'b1; bubbles = 0; cycle();
    chk("flush_ready_kept", bubbles, 0);
    chk("flush_valid", 32'(bus.ex_valid), 0);

    // Reset during a load-use stall with a held instruction in EX
    set_idle(); set_instr(32'h850, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6); cycle();
    set_instr(32'h900, 5'd7, 1'b1, 5'd0, 1'b0, 5'd1);
    bus.ex_ready = 1'b0; load_ex(5'd7); cycle();
    rst = 1'b1; cycle();
    chk("rst_stall_valid", 32'(bus.ex_valid), 0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    rst = 1'b0;

    // Saturation of the stall counter
    set_idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    cycle();
    release dut.stall_cnt_q;
    set_instr(32'hA00, 5'd7, 1'b1, 5'd0, 1'b0, 5'd1);
    load_ex(5'd7);
    repeat (3) cycle();
    chk("sat_stall_cnt", bus.stall_cnt, 32'hFFFF_FFFF);
    rst = 1'b1; set_idle(); rst = 1'b1; cycle(); rst = 1'b0;

    // Random traffic against the reference model
    repeat (1500) begin
      set_random();
      cycle();
    end
    set_idle(); cycle(); cycle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL: de_valid  in  1  decoded instruction present; de_ready  out  1  stage accepts it this cycle.
REQ-004 SHALL: de_pc, de_imm  in  32 each; de_rs1, de_rs2, de_rd  in  5 each; de_use_rs1, de_use_rs2  in  1 each (operand actually read).
REQ-005 SHALL: de_wb_src  in  3, de_mem_op  in  5: control fields using the shared WB_*/MEM_* encodings.
REQ-006 SHALL: rf_rdata1, rf_rdata2  in  32 (register-file read); fwd_sel1, fwd_sel2  in  1; fwd_data1, fwd_data2  in  32 (forwarding-unit outputs).
REQ-007 SHALL: ex_rd_in, m1_rd_in  in  5; ex_wb_src_in, m1_wb_src_in  in  3; ex_mem_op_in, m1_mem_op_in  in  5 (in-flight producers, for load-use).
REQ-008 SHALL: flush  in  1 (redirect kill); ex_ready  in  1 (execute accepts).
REQ-009 SHALL: ex_valid  out  1; ex_pc, ex_op1, ex_op2, ex_imm  out  32; ex_rd  out  5; ex_wb_src  out  3; ex_mem_op  out  5.
REQ-010 SHALL: stall_cnt  out  32  count of interlock bubble cycles, saturating.

Function
REQ-011 SHALL: operand n = fwd_datan when fwd_seln=1, else rf_rdatan; rs=0 yields 0 regardless.
REQ-012 SHALL: hazard_ex = ex_wb_src_in[2] && ex_mem_op_in[4:3]==MEM_READ && ex_rd_in!=0 && ex_rd_in matches a used rs.
REQ-013 SHALL: hazard_m1 = same test against m1_* fields; hazard = hazard_ex || hazard_m1.
REQ-014 SHALL: de_ready = !hazard && (!ex_valid || ex_ready); purely combinational.
REQ-015 SHALL: accept (de_valid && de_ready) registers all ex_* fields with resolved operands, ex_valid=1; latency one cycle.
REQ-016 SHALL: no accept but ex_ready=1 -> ex_valid=0 next cycle (bubble); other ex_* fields hold.
REQ-017 SHALL: ex_valid=1 && ex_ready=0 -> all ex_* outputs hold unchanged.
REQ-018 SHALL: operands sampled only at accept; a stalled instruction re-resolves every cycle.
REQ-019 SHALL: flush -> ex_valid=0 next cycle, overriding accept/hold; de_ready unaffected by flush.
REQ-020 SHALL: stall_cnt increments by 1 each cycle de_valid && hazard && !flush; holds at 32'hFFFF_FFFF.
REQ-021 SHALL: load in EX and dependent in decode -> exactly 2 bubbles; load in M1 -> exactly 1 bubble (assuming ex_ready=1).
REQ-022 SHALL: non-load producer (MEM_READ absent) never causes hazard.

Reset
REQ-023 SHALL: rst=1 -> ex_valid=0, stall_cnt=0, ex_pc/ex_op1/ex_op2/ex_imm=0, ex_rd=0, ex_wb_src=0, ex_mem_op=0 at next edge.
REQ-024 SHALL: rst dominates flush and accept; reset mid-stall discards held instruction, de_ready recomputed from inputs only.

Structure
REQ-025 SHALL: WB_DATAMEM/WB_RESULT/WB_CSR_DATAOUT and MEM_READ encodings live in the shared pipeline package; no local redefinition.
REQ-026 SHALL: hazard logic (REQ-012/013) be a sub-module load_use_detect, purely combinational, instantiated once.

Verification
REQ-027 SHALL: ADD x5 in EX, decode ADD rs1=x5, fwd_sel1=1, fwd_data1=0x1234 -> no stall, next cycle ex_op1=0x1234, ex_valid=1.
REQ-028 SHALL: LW x7 in EX (mem_op[4:3]=MEM_READ), decode uses rs2=x7 -> de_ready=0 two cycles, stall_cnt +2, then accept with m2-forwarded value.
REQ-029 SHALL: same load with de_use_rs2=0 -> no stall; rs1=x0 matching ex_rd_in=0 -> no stall, ex_op1=0.
REQ-030 SHALL: ex_valid=1, ex_ready=0 for 3 cycles -> ex_* stable, de_ready=0; ex_ready=1 -> next instruction loaded.
REQ-031 SHALL: flush coincident with accept -> ex_valid=0 next cycle; rst asserted during load-use stall -> ex_valid=0, stall_cnt=0.
REQ-032 SHALL: force stall_cnt to 0xFFFF_FFFE, hold hazard 3 cycles -> reads 0xFFFF_FFFF, no wrap.
